// File: rtl/seq_alu_w.sv
// Clocked WIDTH-bit ALU with valid/ready handshakes and an iterative restoring remainder unit.
// Optional define SEQ_ALU_DIVZERO_FLAG_EN adds the div_by_zero result flag.
module seq_alu_w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ov,
  output logic             zero_flag,
  output logic             busy
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_REM = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_CAT = 3'd5;
  localparam logic [2:0] OP_EQ  = 3'd6;
  localparam logic [2:0] OP_LT  = 3'd7;

  localparam int MSB = WIDTH - 1;
  localparam int HW  = WIDTH / 2;
  localparam int CW  = $clog2(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             zf_q, zf_d;
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
  logic             dz_q, dz_d;
`endif

  logic             accept;
  logic [WIDTH:0]   sum_w, dif_w, trial_w;
  logic [WIDTH-1:0] trial_sub, rem_next;
  logic [WIDTH-1:0] res_z;
  logic             res_c, res_v, res_zf;

  assign in_ready = rst_n && (state_q == S_IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign sum_w = {1'b0, x} + {1'b0, y};
  assign dif_w = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);

  // Partial remainder stays below the divisor, so the subtraction fits in WIDTH bits.
  assign trial_w   = {rem_q, dvd_q[MSB]};
  assign trial_sub = trial_w[WIDTH-1:0] - dvs_q;
  assign rem_next  = (trial_w >= {1'b0, dvs_q}) ? trial_sub : trial_w[WIDTH-1:0];

  always_comb begin
    res_z  = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_zf = 1'b0;
    case (op)
      OP_ADD: begin
        res_z = sum_w[WIDTH-1:0];
        res_c = sum_w[WIDTH];
        res_v = (x[MSB] == y[MSB]) && (sum_w[MSB] != x[MSB]);
      end
      OP_SUB: begin
        res_z = dif_w[WIDTH-1:0];
        res_c = dif_w[WIDTH];
        res_v = (x[MSB] != y[MSB]) && (dif_w[MSB] != x[MSB]);
      end
      OP_AND: res_z = x & y;
      OP_OR:  res_z = x | y;
      OP_CAT: res_z = {x[HW-1:0], y[HW-1:0]};
      OP_EQ: begin
        res_z  = {{(WIDTH-1){1'b0}}, x == y};
        res_zf = (x == y);
      end
      OP_LT: begin
        res_z = {{(WIDTH-1){1'b0}}, x < y};
        res_c = (x < y);
      end
      default: res_z = '0;
    endcase
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR)
      res_zf = (res_z == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    vld_d   = vld_q && !out_ready;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    zf_d    = zf_q;
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_REM) begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = x;
            dvs_d   = y;
          end else begin
            vld_d = 1'b1;
            z_d   = res_z;
            c_d   = res_c;
            v_d   = res_v;
            zf_d  = res_zf;
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
            dz_d  = 1'b0;
`endif
          end
        end
      end
      S_DIV: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        // A zero divisor always takes the subtract branch, leaving the dividend as remainder.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          vld_d   = 1'b1;
          z_d     = rem_next;
          c_d     = 1'b0;
          v_d     = 1'b0;
          zf_d    = (rem_next == '0);
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
          dz_d    = (dvs_q == '0);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      vld_q   <= 1'b0;
      z_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      zf_q    <= 1'b0;
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      vld_q   <= vld_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
      zf_q    <= zf_d;
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign z         = z_q;
  assign cout      = c_q;
  assign ov        = v_q;
  assign zero_flag = zf_q;
  assign busy      = (state_q == S_DIV);
`ifdef SEQ_ALU_DIVZERO_FLAG_EN
  assign div_by_zero = dz_q;
`endif

endmodule

// File: doc/seq_alu_w.md
Name: seq_alu_w

Overview:
- Parametrised, clocked successor to the team's 8-bit combinational ALU.
- Keeps the same 3-bit opcode map and flag set, generalised to WIDTH bits.
- Adds valid/ready handshakes on input and output, a registered result stage, and a multi-cycle iterative remainder unit.
- Sits between an operand source (register file or sequencer) and a result consumer that may stall.

Parameters:
- WIDTH, 8, operand/result width; even, >= 4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept an operation this cycle
- x  in  WIDTH  operand X
- y  in  WIDTH  operand Y
- op  in  3  0 add, 1 sub, 2 rem, 3 and, 4 or, 5 concat, 6 equal, 7 less-than
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result
- z  out  WIDTH  result
- cout  out  1  carry / less-than flag
- ov  out  1  signed overflow
- zero_flag  out  1  zero / equality flag
- busy  out  1  remainder iteration in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, z=0, cout=0, ov=0, zero_flag=0, busy=0. in_ready=0 while rst_n=0.
- Accept: handshake completes on a clk edge where in_valid && in_ready. x, y and op are captured at that edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Output hold: out_valid, z and flags stay stable until an edge with out_valid && out_ready. out_valid drops on that edge unless a new result is loaded on the same edge.
- Single-cycle ops (all except rem): result registered at the accept edge; out_valid=1 in the following cycle. Throughput 1/cycle when out_ready is held high.
- rem: state IDLE->DIV at accept; busy=1. Restoring division runs one quotient bit per cycle for WIDTH cycles. DIV->IDLE on the final iteration edge, which loads z and flags. out_valid rises WIDTH cycles after the accept edge. in_ready=0 throughout DIV.
- Arithmetic (all results modulo 2^WIDTH):
  - add: z=x+y; cout=carry out of the MSB; ov=signed overflow.
  - sub: z=x-y, computed as x+~y+1; cout=carry out (1 = no borrow); ov=signed overflow.
- Logic and compare ops:
  - rem: z=x mod y (unsigned).
  - and/or: bitwise.
  - concat: z={x[WIDTH/2-1:0], y[WIDTH/2-1:0]}.
  - equal: z={0..., x==y}.
  - less-than: z={0..., x<y} (unsigned).
- zero_flag:
  - (z==0) for add, sub, rem, and, or.
  - x==y for equal.
  - 0 for concat and less-than.
- cout: as defined for add/sub; x<y for less-than; 0 for all other ops.
- ov: add/sub only; 0 for all other ops.
- Divide by zero (y==0): full WIDTH-cycle latency still applies; z=x; zero_flag=(x==0); cout=0, ov=0.
- Reset during DIV aborts the operation: no result is produced and the state returns to IDLE.
- in_valid while in_ready=0 is ignored; the source must hold its operands.

Optional Feature:
- Macro SEQ_ALU_DIVZERO_FLAG_EN.
- When defined:
  - Extra output port div_by_zero (1 bit, reset 0).
  - Set with the rem result when the captured y==0; 0 for every other result.
  - Held and cleared with out_valid, under the same rules as the other flags.
- When undefined: the port is absent and divide-by-zero behaviour is otherwise identical.

Test Plan:
- WIDTH=8, add x=0xFF y=0x01, out_ready=1 -> next cycle out_valid=1, z=0x00, cout=1, ov=0, zero_flag=1; add x=0x7F y=0x01 -> z=0x80, ov=1, cout=0.
- sub x=0x05 y=0x07 -> z=0xFE, cout=0, ov=0, zero_flag=0. Then equal x=0x3C y=0x3C -> z=0x01, zero_flag=1. Then less-than x=0x10 y=0x20 -> z=0x01, cout=1.
- rem x=200 y=7 -> busy=1 and in_ready=0 for 8 cycles; out_valid rises 8 cycles after accept; z=4, zero_flag=0. rem x=9 y=0 -> z=9, div_by_zero=1 (macro on).
- Back-to-back: and x=0xF0 y=0x3C, or x=0xF0 y=0x0F, concat x=0xAB y=0xCD with out_ready=1 on consecutive cycles -> z=0x30, 0xFF, 0xBD on consecutive cycles with no bubbles.
- Backpressure: out_ready=0 after an add result -> z and flags hold, in_ready=0, a new in_valid is not accepted. out_ready=1 -> result consumed and the next op is accepted on the same edge.
- Reset mid-rem: assert rst_n=0 on the 4th DIV cycle -> all outputs 0 immediately and busy=0. After release, the next add 0x02+0x03 -> z=0x05.
